// File: rtl/fifo_bit_reader_if.sv
// Request/response and FIFO read-port signal bundle for fifo_bit_reader.
// The slave modport is the reader's view; master is the driving side.
interface fifo_bit_reader_if #(
   parameter int DWIDTH = 8,
   parameter int NBMAX  = 15
) ();
   logic              fifo_empty_i;
   logic [DWIDTH-1:0] fifo_data_i;
   logic              fifo_re_o;
   logic              req_i;
   logic [3:0]        nbits_i;
   logic              flush_i;
   logic [NBMAX-1:0]  bits_o;
   logic              bits_valid_o;
   logic              busy_o;

   modport slave (
      input  fifo_empty_i, fifo_data_i, req_i, nbits_i, flush_i,
      output fifo_re_o, bits_o, bits_valid_o, busy_o
   );

   modport master (
      output fifo_empty_i, fifo_data_i, req_i, nbits_i, flush_i,
      input  fifo_re_o, bits_o, bits_valid_o, busy_o
   );
endinterface

// File: rtl/fifo_bit_reader.sv
// Byte-FIFO to variable-width (0..15 bit, LSB-first) bit extractor with carry-over reservoir.
// Optional FIFO_BIT_READER_STALL_CNT_EN adds a saturating empty-stall counter on stall_cnt_o.
module fifo_bit_reader #(
   parameter int DWIDTH = 8,
   parameter int NBMAX  = 15
) (
   input  logic             clk,
   input  logic             reset,
   fifo_bit_reader_if.slave bus
`ifdef FIFO_BIT_READER_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [23:0]      res_q;
   logic [4:0]       cnt_q;
   logic [3:0]       n_q;
   logic [NBMAX-1:0] bits_q;
   logic             valid_q;

   logic [23:0]      mask;
   logic [NBMAX-1:0] bits_d;
   logic [23:0]      res_cap_d;
   logic [4:0]       cnt_cap_d;
   logic [23:0]      res_done_d;
   logic [4:0]       cnt_done_d;
   logic             flush_ok;

   always_comb begin
      mask       = (24'd1 << n_q) - 24'd1;
      bits_d     = res_q[NBMAX-1:0] & mask[NBMAX-1:0];
      // new byte lands just above the bits already held
      res_cap_d  = res_q | ({{(24-DWIDTH){1'b0}}, bus.fifo_data_i} << cnt_q);
      cnt_cap_d  = cnt_q + 5'd8;
      res_done_d = res_q >> n_q;
      cnt_done_d = cnt_q - {1'b0, n_q};
      flush_ok   = (state_q == S_IDLE) && bus.flush_i && !bus.req_i;
   end

   assign bus.fifo_re_o    = (state_q == S_READ) && !bus.fifo_empty_i;
   assign bus.busy_o       = (state_q != S_IDLE);
   assign bus.bits_o       = bits_q;
   assign bus.bits_valid_o = valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         res_q   <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         bits_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req_i) begin
                  n_q     <= bus.nbits_i;
                  state_q <= (cnt_q >= {1'b0, bus.nbits_i}) ? S_DONE : S_READ;
               end else if (flush_ok) begin
                  res_q <= '0;
                  cnt_q <= '0;
               end
            end
            S_READ: begin
               if (!bus.fifo_empty_i) state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               res_q   <= res_cap_d;
               cnt_q   <= cnt_cap_d;
               state_q <= (cnt_cap_d >= {1'b0, n_q}) ? S_DONE : S_READ;
            end
            S_DONE: begin
               bits_q  <= bits_d;
               valid_q <= 1'b1;
               res_q   <= res_done_d;
               cnt_q   <= cnt_done_d;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef FIFO_BIT_READER_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset || flush_ok) begin
         stall_cnt_q <= '0;
      end else if ((state_q == S_READ) && bus.fifo_empty_i && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
